// File: rtl/ofdm_rx_symbol_framer.sv
`timescale 1ns/1ps
// ofdm_rx_symbol_framer
// ---------------------
// Receive-side OFDM symbol framer between the DDC sample stream and the RX DMA.
// The DDC stream is packed I/Q with I in [15:0] and Q in [31:16], and it has no
// tlast. After an arming pulse, the framer:
//   1. discards i_offset samples,
//   2. strips CP_LEN cyclic-prefix samples in front of every symbol,
//   3. forwards NFFT samples per symbol as one AXI4-Stream packet of
//      i_num_symbols symbols.
// tuser flags the first sample of each symbol. tlast flags the final sample of
// the packet.
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   i_start                    one-cycle arm pulse (ignored while o_busy)
//   i_offset, i_num_symbols    capture setup, sampled on an accepted i_start
//   s_axis_*                   DDC sample stream in (tdata/tvalid/tready)
//   m_axis_*                   framed symbol stream out (tdata/tvalid/tready/tlast/tkeep/tuser)
//   o_busy                     capture in progress or output register still full
//   o_sym_count                symbols fully handed downstream in this packet
module ofdm_rx_symbol_framer #(
    parameter int NFFT   = 4096,
    parameter int CP_LEN = 256,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                i_start,
    input  logic [15:0]         i_offset,
    input  logic [7:0]          i_num_symbols,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tuser,
    output logic                o_busy,
    output logic [7:0]          o_sym_count
);

    localparam int IDX_W = $clog2(NFFT);
    localparam int CP_W  = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFFT - 1);
    localparam logic [CP_W-1:0]  CP_LAST  = CP_W'(CP_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_CP, S_DATA} state_t;

    state_t              state_q,     state_d;
    logic [15:0]         off_len_q,   off_len_d;
    logic [15:0]         off_cnt_q,   off_cnt_d;
    logic [7:0]          num_sym_q,   num_sym_d;
    logic [7:0]          sym_q,       sym_d;
    logic [CP_W-1:0]     cp_cnt_q,    cp_cnt_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [DATA_W-1:0]   tdata_q,     tdata_d;
    logic                tvalid_q,    tvalid_d;
    logic                tlast_q,     tlast_d;
    logic                tuser_q,     tuser_d;
    logic                eos_q,       eos_d;      // register holds a symbol's final sample
    logic [7:0]          sym_count_q, sym_count_d;

    logic in_ready;
    logic in_beat;
    logic out_hs;
    logic last_of_sym;
    logic final_sym;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        // Outside DATA every sample is dropped; in DATA the single output
        // register only takes a new sample when it is empty or draining.
        in_ready    = (state_q != S_DATA) | ~tvalid_q | m_axis_tready;
        in_beat     = s_axis_tvalid & in_ready;
        out_hs      = tvalid_q & m_axis_tready;
        last_of_sym = (idx_q == IDX_LAST);
        final_sym   = (sym_q == num_sym_q - 8'd1);

        state_d     = state_q;
        off_len_d   = off_len_q;
        off_cnt_d   = off_cnt_q;
        num_sym_d   = num_sym_q;
        sym_d       = sym_q;
        cp_cnt_d    = cp_cnt_q;
        idx_d       = idx_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        eos_d       = eos_q;
        sym_count_d = sym_count_q;

        if (out_hs) begin
            tvalid_d = 1'b0;
            if (eos_q) begin
                sym_count_d = sat_inc8(sym_count_q);
            end
        end

        case (state_q)
            S_IDLE: begin
                // Requiring an empty output register also rejects a start
                // in the cycle right after the last sample was loaded.
                if (i_start && !tvalid_q) begin
                    off_len_d   = i_offset;
                    num_sym_d   = (i_num_symbols == 8'd0) ? 8'd1 : i_num_symbols;
                    sym_count_d = 8'd0;
                    sym_d       = 8'd0;
                    off_cnt_d   = 16'd0;
                    cp_cnt_d    = '0;
                    idx_d       = '0;
                    state_d     = (i_offset != 16'd0) ? S_OFFSET : S_CP;
                end
            end
            S_OFFSET: begin
                if (in_beat) begin
                    if (off_cnt_q == off_len_q - 16'd1) begin
                        off_cnt_d = 16'd0;
                        state_d   = S_CP;
                    end else begin
                        off_cnt_d = off_cnt_q + 16'd1;
                    end
                end
            end
            S_CP: begin
                if (in_beat) begin
                    if (cp_cnt_q == CP_LAST) begin
                        cp_cnt_d = '0;
                        idx_d    = '0;
                        state_d  = S_DATA;
                    end else begin
                        cp_cnt_d = cp_cnt_q + CP_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (in_beat) begin
                    tdata_d  = s_axis_tdata;
                    tvalid_d = 1'b1;
                    tuser_d  = (idx_q == '0);
                    tlast_d  = last_of_sym & final_sym;
                    eos_d    = last_of_sym;
                    if (last_of_sym) begin
                        idx_d   = '0;
                        sym_d   = sym_q + 8'd1;
                        state_d = final_sym ? S_IDLE : S_CP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            off_len_q   <= '0;
            off_cnt_q   <= '0;
            num_sym_q   <= '0;
            sym_q       <= '0;
            cp_cnt_q    <= '0;
            idx_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            eos_q       <= 1'b0;
            sym_count_q <= '0;
        end else begin
            state_q     <= state_d;
            off_len_q   <= off_len_d;
            off_cnt_q   <= off_cnt_d;
            num_sym_q   <= num_sym_d;
            sym_q       <= sym_d;
            cp_cnt_q    <= cp_cnt_d;
            idx_q       <= idx_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            eos_q       <= eos_d;
            sym_count_q <= sym_count_d;
        end
    end

    // Gating with aresetn forces every output low while reset is asserted.
    assign s_axis_tready = aresetn & in_ready;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tvalid_q & tlast_q;
    assign m_axis_tuser  = tvalid_q & tuser_q;
    assign m_axis_tkeep  = {(DATA_W/8){tvalid_q}};
    assign o_busy        = (state_q != S_IDLE) | tvalid_q;
    assign o_sym_count   = sym_count_q;

endmodule

// File: tb/tb_ofdm_rx_symbol_framer.sv
`timescale 1ns/1ps
// Scoreboard bench for ofdm_rx_symbol_framer with NFFT=16 and CP_LEN=4. The
// input is a counter stream that restarts at 0 right after each start pulse.
module tb_ofdm_rx_symbol_framer;

    localparam int NFFT   = 16;
    localparam int CP_LEN = 4;
    localparam int DATA_W = 32;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              i_start;
    logic [15:0]       i_offset;
    logic [7:0]        i_num_symbols;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [3:0]        m_axis_tkeep;
    logic              m_axis_tuser;
    logic              o_busy;
    logic [7:0]        o_sym_count;

    ofdm_rx_symbol_framer #(.NFFT(NFFT), .CP_LEN(CP_LEN), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .i_start(i_start), .i_offset(i_offset),
        .i_num_symbols(i_num_symbols), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .o_busy(o_busy), .o_sym_count(o_sym_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt;            // next input sample value
    int   k;              // cycles since the last start pulse
    logic beat;
    logic stream_en;
    logic rand_v;
    logic tr_mode;
    logic stall_chk;
    logic busy_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference framing: symbol s starts at input sample off + CP + s*(CP+NFFT).
    task automatic push_exp(input int off, input int num);
        int n;
        int base;
        exp_t it;
        n = (num == 0) ? 1 : num;
        for (int s = 0; s < n; s++) begin
            base = off + CP_LEN + s * (CP_LEN + NFFT);
            for (int j = 0; j < NFFT; j++) begin
                it.data = 32'(base + j);
                it.user = (j == 0);
                it.last = (s == n - 1) && (j == NFFT - 1);
                exp_q.push_back(it);
            end
        end
    endtask

    // One clock cycle: note the input beat, then update stimulus 1 ns after the edge.
    task automatic step();
        @(negedge aclk);
        beat = s_axis_tvalid & s_axis_tready;
        @(posedge aclk);
        #1;
        k++;
        if (beat) cnt++;
        if (!stream_en) begin
            cnt = 0;
            s_axis_tvalid = 1'b0;
        end else if (rand_v) begin
            if (!s_axis_tvalid || beat) s_axis_tvalid = 1'($urandom_range(0, 1));
        end else begin
            s_axis_tvalid = 1'b1;
        end
        s_axis_tdata = 32'(cnt);
        if (!tr_mode) m_axis_tready = 1'b1;
        else m_axis_tready = (k >= 14 && k < 19) ? 1'b0 : (k % 2 == 1);
    endtask

    task automatic start_pkt(input int off, input int num);
        push_exp(off, num);
        i_offset      = 16'(off);
        i_num_symbols = 8'(num);
        i_start       = 1'b1;
        s_axis_tvalid = 1'b0;
        cnt           = 0;
        s_axis_tdata  = '0;
        stream_en     = 1'b1;
        k             = 0;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_syms);
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || o_busy) && budget < 3000) begin
            step();
            budget++;
        end
        check_eq({tag, "_done_in_time"}, 64'(budget < 3000), 64'd1);
        check_eq({tag, "_sym_count"}, 64'(o_sym_count), 64'(exp_syms));
        check_eq({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        step();
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (busy_chk) begin
                check_eq("busy_fall_after_tlast", 64'(o_busy), 64'd0);
                busy_chk = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat_queue_size", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_t it;
                    it = exp_q.pop_front();
                    check_eq("out_tdata", 64'(m_axis_tdata), 64'(it.data));
                    check_eq("out_tuser", 64'(m_axis_tuser), 64'(it.user));
                    check_eq("out_tlast", 64'(m_axis_tlast), 64'(it.last));
                    check_eq("out_tkeep", 64'(m_axis_tkeep), 64'hF);
                    if (it.last) busy_chk = 1'b1;
                end
            end
            if (stall_chk && m_axis_tvalid && !m_axis_tready && !m_axis_tlast)
                check_eq("stall_s_tready", 64'(s_axis_tready), 64'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check_eq({tag, "_m_tdata"},  64'(m_axis_tdata),  64'd0);
        check_eq({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
        check_eq({tag, "_m_tuser"},  64'(m_axis_tuser),  64'd0);
        check_eq({tag, "_m_tkeep"},  64'(m_axis_tkeep),  64'd0);
        check_eq({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        check_eq({tag, "_busy"},     64'(o_busy),        64'd0);
        check_eq({tag, "_sym_cnt"},  64'(o_sym_count),   64'd0);
    endtask

    initial begin
        int budget;
        aresetn       = 1'b0;
        i_start       = 1'b0;
        i_offset      = '0;
        i_num_symbols = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cnt = 0; k = 0; beat = 1'b0;
        stream_en = 1'b0; rand_v = 1'b0; tr_mode = 1'b0; stall_chk = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        step();
        check_eq("idle_s_tready", 64'(s_axis_tready), 64'd1);
        check_eq("idle_busy", 64'(o_busy), 64'd0);

        // Basic single symbol.
        start_pkt(0, 1);
        check_eq("busy_after_start", 64'(o_busy), 64'd1);
        wait_done("s1", 1);

        // Offset then two symbols.
        start_pkt(3, 2);
        wait_done("s2", 2);

        // Toggling downstream ready with a 5-cycle stall.
        tr_mode = 1'b1; stall_chk = 1'b1;
        start_pkt(0, 1);
        wait_done("s3", 1);
        tr_mode = 1'b0; stall_chk = 1'b0;
        m_axis_tready = 1'b1;

        // Random input valid.
        rand_v = 1'b1;
        start_pkt(0, 1);
        wait_done("s4", 1);
        rand_v = 1'b0;

        // Restart pulse mid-packet must be ignored.
        start_pkt(0, 2);
        repeat (10) step();
        i_start = 1'b1; i_offset = 16'd5; i_num_symbols = 8'd1;
        step();
        i_start = 1'b0;
        wait_done("s5", 2);

        // Zero symbol count behaves as one.
        start_pkt(0, 0);
        wait_done("s6", 1);

        // Reset while at DATA index 8 (input sample 12).
        start_pkt(0, 1);
        budget = 0;
        while (!(m_axis_tvalid && m_axis_tdata == 32'd12) && budget < 200) begin
            step();
            budget++;
        end
        check_eq("s7_reached_index8", 64'(budget < 200), 64'd1);
        exp_q.delete();
        aresetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        stream_en = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        step();
        check_eq("post_reset_busy", 64'(o_busy), 64'd0);
        start_pkt(0, 1);
        wait_done("s7", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_rx_symbol_framer.md
Name: ofdm_rx_symbol_framer

Overview:
- Receive-side counterpart of the transmit sample feeder. Sits after the DDC output stream and before the RX DMA.
- Consumes the continuous baseband I/Q stream from the DDC: I in bits [15:0], Q in [31:16], no tlast.
- Skips a programmable timing offset, then strips the cyclic prefix of each OFDM symbol.
- Emits NFFT-sample symbols as an AXI4-Stream packet. tuser marks the first sample of each symbol; tlast marks the final sample of the final symbol.

Parameters:
- NFFT, 4096, FFT length in samples per symbol (power of 2, ≥8).
- CP_LEN, 256, cyclic prefix length in samples (≥1, < NFFT).
- DATA_W, 32, sample width (packed I/Q).

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse that arms a capture; ignored while o_busy=1.
- i_offset  in  16  samples to discard before the first CP; sampled on i_start.
- i_num_symbols  in  8  symbols per packet; 0 is treated as 1; sampled on i_start.
- s_axis_tdata  in  DATA_W  DDC sample.
- s_axis_tvalid  in  1  DDC sample valid.
- s_axis_tready  out  1  framer accepts sample.
- m_axis_tdata  out  DATA_W  framed sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last sample of packet.
- m_axis_tkeep  out  DATA_W/8  all ones whenever tvalid=1.
- m_axis_tuser  out  1  first sample of a symbol.
- o_busy  out  1  capture in progress (state != IDLE, or output register still full).
- o_sym_count  out  8  symbols fully emitted in the current packet.

Behaviour:
- Reset: all outputs 0 except m_axis_tkeep, which is 0 while m_axis_tvalid=0. State=IDLE, all counters 0. Asserting reset mid-packet aborts immediately. No partial tlast is generated.
- Input handshake "beat": s_axis_tvalid & s_axis_tready. Output handshake: m_axis_tvalid & m_axis_tready. Only beats advance the counters.
- s_axis_tready:
  - 1 in IDLE, OFFSET and CP; samples are dropped. IDLE drains the DDC while no capture is armed.
  - In DATA: s_axis_tready = !m_axis_tvalid | m_axis_tready (single output register; backpressure propagates).
- States:
  - IDLE: on i_start, latch offset and symbol count, clear o_sym_count. Go to OFFSET if offset>0, else CP.
  - OFFSET: count beats; after i_offset beats, go to CP.
  - CP: count beats; after CP_LEN beats, go to DATA with sample index=0.
  - DATA: each beat loads the output register with:
    - tdata = s_axis_tdata
    - tuser = (index==0)
    - tlast = (index==NFFT-1) & (symbol==num_symbols-1)
  - At index NFFT-1: increment symbol counter. If it was the final symbol, go to IDLE; else go to CP.
- Output register:
  - Holds data, tvalid, tlast and tuser stable until accepted.
  - tvalid clears on accept unless a new beat loads in the same cycle.
  - Latency: 1 cycle from input beat to m_axis_tvalid.
- o_sym_count increments on the output handshake of each symbol's index NFFT-1 sample. Saturates at 255.
- i_start while busy: ignored. A new i_start in the same cycle the FSM returns to IDLE is also ignored.
- Counters are sized clog2 of their range. Boundaries:
  - offset 65535 counts fully.
  - CP/DATA index wraps to 0 exactly at CP_LEN-1 / NFFT-1.
- In DATA, a stall on m_axis_tready holds s_axis_tready low. No sample is lost or duplicated.

Test Plan:
- Bench parameters: NFFT=16, CP_LEN=4.
- Input stream: incrementing counter samples 0,1,2,… with continuous tvalid and tready=1.
- Scenarios:
  - Start, offset=0, num=1 -> 16 output beats with data 4..19; tuser on 4; tlast on 19; o_sym_count=1; o_busy falls 1 cycle after the tlast handshake.
  - Start, offset=3, num=2 -> data 7..22 then 27..42; tuser on 7 and 27; tlast only on 42; o_sym_count ends at 2.
  - Same as the first scenario with m_axis_tready toggling 1-0-1-0 and a 5-cycle stall mid-symbol -> the output sequence is identical, s_axis_tready is low during the stalls, and no gaps or repeats occur in the data values.
  - s_axis_tvalid random (50%) during OFFSET/CP/DATA -> same data values as the first scenario; only beats count.
  - i_start pulsed again mid-packet -> ignored; packet length unchanged. num_symbols=0 -> behaves as 1.
  - aresetn asserted at DATA index 8 -> all outputs 0 asynchronously. After release and a new start (offset=0, num=1), output begins at 4 CP samples after restart with tuser set; no stale tlast.
